// File: rtl/ccip_avmm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ccip_avmm_pkg
//  Description : Shared types for the CCI-P MMIO to Avalon-MM bridge.
//                Contains the decoded MMIO command, the master command queue
//                entry, the read tag, and the command-to-master conversion.
//  Revision    : 1.0  initial release
// ============================================================================
package ccip_avmm_pkg;

    localparam int MMIO_TID_WIDTH = 9;
    localparam int AVM_ADDR_WIDTH = 18;

    // Decoded MMIO packet as delivered by the CCI-P MMIO decoder.
    typedef struct packed {
        logic                      is_read;
        logic                      is_32bit;
        logic [AVM_ADDR_WIDTH-1:0] addr;
        logic [63:0]               write_data;
    } t_ccip_avmm_mmio_cmd;

    // One Avalon-MM master request, already lane-steered.
    typedef struct packed {
        logic [AVM_ADDR_WIDTH-1:0] address;
        logic [7:0]                byteenable;
        logic [63:0]               writedata;
        logic                      read;
        logic                      write;
    } t_master_cmd_queue;

    // Bookkeeping needed to shape and tag a read response.
    typedef struct packed {
        logic [MMIO_TID_WIDTH-1:0] tid;
        logic                      is_32bit;
        logic                      upper;
    } t_mmio_rd_tag;

    // Command buffer entry: request plus the tag to use if it is a read.
    typedef struct packed {
        t_master_cmd_queue mc;
        t_mmio_rd_tag      tag;
    } t_cmd_entry;

    // 32-bit accesses select a half of the 64-bit word with addr[2]; write
    // data is replicated into both halves so the enabled lanes carry it.
    function automatic t_master_cmd_queue mmio_cmd_to_master(input t_ccip_avmm_mmio_cmd c);
        t_master_cmd_queue m;
        m.address = {c.addr[AVM_ADDR_WIDTH-1:3], 3'b000};
        if (c.is_32bit) begin
            m.byteenable = c.addr[2] ? 8'hF0 : 8'h0F;
            m.writedata  = {2{c.write_data[31:0]}};
        end else begin
            m.byteenable = 8'hFF;
            m.writedata  = c.write_data;
        end
        m.read  = c.is_read;
        m.write = !c.is_read;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ccip_avmm_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ccip_avmm_sync_fifo
//  Description : Single-clock show-ahead FIFO. The head entry is visible on
//                o_rd_data whenever o_empty is low. Pushes while full and pops
//                while empty are ignored (a push while full is dropped even if
//                a pop happens in the same cycle).
//  Ports       : clk, rst (sync, active-high), i_push/i_wr_data, i_pop,
//                o_rd_data, o_full, o_empty, o_count
//  Revision    : 1.0  initial release
// ============================================================================
module ccip_avmm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == c_CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + c_CW'(w_push_ok) - c_CW'(w_pop_ok);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ccip_avmm_mmio_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ccip_avmm_mmio_sequencer
//  Description : Buffers decoded CCI-P MMIO commands, converts them to
//                Avalon-MM requests, issues them in order under waitrequest,
//                caps outstanding reads and returns tid-tagged read data.
//  Ports       : clk, reset (sync, active-high)
//                cmd_valid/cmd/cmd_tid, cmd_almost_full   - MMIO side
//                avm_*                                    - Avalon-MM master
//                rsp_valid/rsp_tid/rsp_data               - read responses
//                err_overflow, err_orphan_rsp             - sticky errors
//  Revision    : 1.0  initial release
// ============================================================================
module ccip_avmm_mmio_sequencer
    import ccip_avmm_pkg::*;
#(
    parameter int CMD_FIFO_DEPTH     = 8,
    parameter int MAX_RD_OUTSTANDING = 4,
    // Must not exceed MMIO_TID_WIDTH; the tag store is sized by the package.
    parameter int TID_WIDTH          = MMIO_TID_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    input  t_ccip_avmm_mmio_cmd       cmd,
    input  logic [TID_WIDTH-1:0]      cmd_tid,
    output logic                      cmd_almost_full,
    output logic [AVM_ADDR_WIDTH-1:0] avm_address,
    output logic [7:0]                avm_byteenable,
    output logic [63:0]               avm_writedata,
    output logic                      avm_read,
    output logic                      avm_write,
    input  logic                      avm_waitrequest,
    input  logic [63:0]               avm_readdata,
    input  logic                      avm_readdatavalid,
    output logic                      rsp_valid,
    output logic [TID_WIDTH-1:0]      rsp_tid,
    output logic [63:0]               rsp_data,
    output logic                      err_overflow,
    output logic                      err_orphan_rsp
);

    localparam int c_CMD_CW  = $clog2(CMD_FIFO_DEPTH) + 1;
    localparam int c_TAG_CW  = $clog2(MAX_RD_OUTSTANDING) + 1;
    localparam int c_ENTRY_W = $bits(t_cmd_entry);
    localparam int c_TAG_W   = $bits(t_mmio_rd_tag);

    // ---------------------------------------------------------------- command buffer
    t_cmd_entry          w_push_entry;
    t_cmd_entry          w_head;
    logic                w_cmd_push;
    logic                w_cmd_pop;
    logic                w_cmd_full;
    logic                w_cmd_empty;
    logic [c_CMD_CW-1:0] w_cmd_count;
    logic [c_CMD_CW-1:0] w_cmd_next_count;

    always_comb begin
        w_push_entry.mc           = mmio_cmd_to_master(cmd);
        w_push_entry.tag.tid      = MMIO_TID_WIDTH'(cmd_tid);
        w_push_entry.tag.is_32bit = cmd.is_32bit;
        w_push_entry.tag.upper    = cmd.addr[2];
    end

    assign w_cmd_push = cmd_valid && !w_cmd_full;

    ccip_avmm_sync_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_push    (w_cmd_push),
        .i_wr_data (w_push_entry),
        .i_pop     (w_cmd_pop),
        .o_rd_data (w_head),
        .o_full    (w_cmd_full),
        .o_empty   (w_cmd_empty),
        .o_count   (w_cmd_count)
    );

    // ---------------------------------------------------------------- issue
    logic                r_outstanding_dummy_unused;
    logic [c_TAG_CW-1:0] r_outstanding;
    logic                w_head_valid;
    logic                w_rd_blocked;
    logic                w_avm_read;
    logic                w_avm_write;
    logic                w_rd_accept;

    assign w_head_valid = !w_cmd_empty;
    assign w_rd_blocked = (r_outstanding == c_TAG_CW'(MAX_RD_OUTSTANDING));
    assign w_avm_read   = w_head_valid && w_head.mc.read && !w_rd_blocked;
    assign w_avm_write  = w_head_valid && w_head.mc.write;
    // The head only moves on acceptance, so every avm_* output stays put
    // for as long as the slave stalls.
    assign w_cmd_pop    = (w_avm_read || w_avm_write) && !avm_waitrequest;
    assign w_rd_accept  = w_avm_read && !avm_waitrequest;

    assign avm_read       = w_avm_read;
    assign avm_write      = w_avm_write;
    assign avm_address    = w_head_valid ? w_head.mc.address    : '0;
    assign avm_byteenable = w_head_valid ? w_head.mc.byteenable : '0;
    assign avm_writedata  = w_head_valid ? w_head.mc.writedata  : '0;

    assign w_cmd_next_count = w_cmd_count + c_CMD_CW'(w_cmd_push) - c_CMD_CW'(w_cmd_pop);

    // ---------------------------------------------------------------- read tags
    t_mmio_rd_tag        w_tag_head;
    logic                w_tag_pop;
    logic                w_tag_full;
    logic                w_tag_empty;
    logic [c_TAG_CW-1:0] w_tag_count;
    logic [63:0]         w_rsp_data_sel;

    // Reads stop issuing at MAX_RD_OUTSTANDING, so this FIFO never overflows.
    ccip_avmm_sync_fifo #(
        .WIDTH (c_TAG_W),
        .DEPTH (MAX_RD_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_push    (w_rd_accept),
        .i_wr_data (w_head.tag),
        .i_pop     (w_tag_pop),
        .o_rd_data (w_tag_head),
        .o_full    (w_tag_full),
        .o_empty   (w_tag_empty),
        .o_count   (w_tag_count)
    );

    // Data with no matching tag is an orphan and is not consumed as a response.
    assign w_tag_pop = avm_readdatavalid && !w_tag_empty;

    always_comb begin
        w_rsp_data_sel = avm_readdata;
        if (w_tag_head.is_32bit) begin
            w_rsp_data_sel = w_tag_head.upper ? {32'b0, avm_readdata[63:32]}
                                              : {32'b0, avm_readdata[31:0]};
        end
    end

    // ---------------------------------------------------------------- registered state
    logic                 r_almost_full;
    logic                 r_rsp_valid;
    logic [TID_WIDTH-1:0] r_rsp_tid;
    logic [63:0]          r_rsp_data;
    logic                 r_err_overflow;
    logic                 r_err_orphan;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_almost_full  <= 1'b0;
            r_outstanding  <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_tid      <= '0;
            r_rsp_data     <= '0;
            r_err_overflow <= 1'b0;
            r_err_orphan   <= 1'b0;
        end else begin
            r_almost_full <= (w_cmd_next_count >= c_CMD_CW'(CMD_FIFO_DEPTH - 2));
            r_outstanding <= r_outstanding + c_TAG_CW'(w_rd_accept) - c_TAG_CW'(w_tag_pop);
            r_rsp_valid   <= w_tag_pop;
            if (w_tag_pop) begin
                r_rsp_tid  <= TID_WIDTH'(w_tag_head.tid);
                r_rsp_data <= w_rsp_data_sel;
            end
            if (cmd_valid && w_cmd_full) begin
                r_err_overflow <= 1'b1;
            end
            if (avm_readdatavalid && w_tag_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign r_outstanding_dummy_unused = 1'b0;

    assign cmd_almost_full = r_almost_full;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_tid         = r_rsp_tid;
    assign rsp_data        = r_rsp_data;
    assign err_overflow    = r_err_overflow;
    assign err_orphan_rsp  = r_err_orphan;

    // Tag FIFO status is implied by r_outstanding and not otherwise needed.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, w_tag_full, w_tag_count, r_outstanding_dummy_unused};

endmodule
`default_nettype wire

// File: tb/tb_ccip_avmm_mmio_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccip_avmm_mmio_sequencer
//  Description : Directed self-checking bench for ccip_avmm_mmio_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ccip_avmm_mmio_sequencer;
    import ccip_avmm_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cmd_valid;
    t_ccip_avmm_mmio_cmd  cmd;
    logic [8:0]           cmd_tid;
    logic                 cmd_almost_full;
    logic [17:0]          avm_address;
    logic [7:0]           avm_byteenable;
    logic [63:0]          avm_writedata;
    logic                 avm_read;
    logic                 avm_write;
    logic                 avm_waitrequest;
    logic [63:0]          avm_readdata;
    logic                 avm_readdatavalid;
    logic                 rsp_valid;
    logic [8:0]           rsp_tid;
    logic [63:0]          rsp_data;
    logic                 err_overflow;
    logic                 err_orphan_rsp;

    always #5 clk = ~clk;

    ccip_avmm_mmio_sequencer #(
        .CMD_FIFO_DEPTH     (8),
        .MAX_RD_OUTSTANDING (4),
        .TID_WIDTH          (9)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd               (cmd),
        .cmd_tid           (cmd_tid),
        .cmd_almost_full   (cmd_almost_full),
        .avm_address       (avm_address),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .rsp_valid         (rsp_valid),
        .rsp_tid           (rsp_tid),
        .rsp_data          (rsp_data),
        .err_overflow      (err_overflow),
        .err_orphan_rsp    (err_orphan_rsp)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accepted-request observer, sampled mid-cycle when everything is settled.
    int          rd_acc = 0;
    int          wr_cnt = 0;
    logic [63:0] wr_data_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (avm_read && !avm_waitrequest) rd_acc++;
            if (avm_write && !avm_waitrequest) begin
                wr_cnt++;
                wr_data_q.push_back(avm_writedata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic rd, input logic is32, input logic [17:0] a,
                        input logic [63:0] d, input logic [8:0] tid);
        cmd_valid       = 1'b1;
        cmd.is_read     = rd;
        cmd.is_32bit    = is32;
        cmd.addr        = a;
        cmd.write_data  = d;
        cmd_tid         = tid;
        step();
        cmd_valid       = 1'b0;
    endtask

    task automatic rdv_pulse(input logic [63:0] d);
        avm_readdatavalid = 1'b1;
        avm_readdata      = d;
        step();
        avm_readdatavalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        reset             = 1'b1;
        cmd_valid         = 1'b0;
        cmd               = '0;
        cmd_tid           = '0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_write", avm_write, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_almost_full", cmd_almost_full, 0);
        chk("rst_err", {err_overflow, err_orphan_rsp}, 0);
        reset = 1'b0;
        step();

        // 64-bit write, no stall
        push(1'b0, 1'b0, 18'h00108, 64'hDEAD_BEEF_0123_4567, 9'h0);
        chk("w64_write", avm_write, 1);
        chk("w64_addr", avm_address, 18'h00108);
        chk("w64_be", avm_byteenable, 8'hFF);
        chk("w64_data", avm_writedata, 64'hDEAD_BEEF_0123_4567);
        step();
        chk("w64_done", avm_write, 0);

        // 32-bit upper write held by waitrequest
        avm_waitrequest = 1'b1;
        push(1'b0, 1'b1, 18'h0010C, 64'h0000_0000_AABB_CCDD, 9'h0);
        for (int i = 0; i < 4; i++) begin
            chk("w32_write", avm_write, 1);
            chk("w32_addr", avm_address, 18'h00108);
            chk("w32_be", avm_byteenable, 8'hF0);
            chk("w32_data", avm_writedata, 64'hAABBCCDD_AABBCCDD);
            if (i < 3) step();
        end
        avm_waitrequest = 1'b0;
        base = wr_cnt;
        step();
        chk("w32_popped", avm_write, 0);
        chk("w32_one_pop", wr_cnt - base, 1);
        step();
        chk("w32_still_one", wr_cnt - base, 1);

        // Six reads, cap of four outstanding
        base = rd_acc;
        for (int t = 1; t <= 6; t++) begin
            push(1'b1, 1'b0, 18'(18'h00200 + 18'(8 * t)), 64'h0, 9'(t));
        end
        repeat (3) step();
        chk("rd_cap_count", rd_acc - base, 4);
        chk("rd_cap_blocked", avm_read, 0);
        rdv_pulse(64'h1000_0000_0000_0001);
        chk("rsp1_valid", rsp_valid, 1);
        chk("rsp1_tid", rsp_tid, 9'd1);
        chk("rsp1_data", rsp_data, 64'h1000_0000_0000_0001);
        chk("rd5_unblocked", avm_read, 1);
        step();
        chk("rd5_accepted", rd_acc - base, 5);
        for (int k = 2; k <= 6; k++) begin
            rdv_pulse(64'h1000_0000_0000_0000 + 64'(k));
            chk("rspk_valid", rsp_valid, 1);
            chk("rspk_tid", rsp_tid, 9'(k));
            chk("rspk_data", rsp_data, 64'h1000_0000_0000_0000 + 64'(k));
            step();
            step();
        end
        chk("rd_all_accepted", rd_acc - base, 6);
        chk("rd_none_pending", avm_read, 0);
        chk("rsp_pulse_end", rsp_valid, 0);

        // 32-bit upper read
        push(1'b1, 1'b1, 18'h00204, 64'h0, 9'h1A5);
        chk("r32_read", avm_read, 1);
        chk("r32_addr", avm_address, 18'h00200);
        chk("r32_be", avm_byteenable, 8'hF0);
        step();
        rdv_pulse(64'h11223344_55667788);
        chk("r32_valid", rsp_valid, 1);
        chk("r32_tid", rsp_tid, 9'h1A5);
        chk("r32_data", rsp_data, 64'h00000000_11223344);
        step();
        chk("r32_pulse", rsp_valid, 0);

        // Fill buffer under stall, overflow, drain
        avm_waitrequest = 1'b1;
        base = wr_cnt;
        for (int i = 0; i < 8; i++) begin
            push(1'b0, 1'b0, 18'(18'h00300 + 18'(8 * i)), 64'hC0DE_0000_0000_0000 + 64'(i), 9'h0);
            if (i == 4) chk("af_after5", cmd_almost_full, 0);
            if (i == 5) chk("af_after6", cmd_almost_full, 1);
        end
        chk("ovf_before", err_overflow, 0);
        push(1'b0, 1'b0, 18'h00400, 64'hBAD0_BAD0_BAD0_BAD0, 9'h0);
        chk("ovf_set", err_overflow, 1);
        chk("af_full", cmd_almost_full, 1);
        avm_waitrequest = 1'b0;
        repeat (12) step();
        chk("drain_count", wr_cnt - base, 8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < wr_data_q.size())
                chk("drain_data", wr_data_q[base + i], 64'hC0DE_0000_0000_0000 + 64'(i));
            else
                chk("drain_missing", 64'd0, 64'd1);
        end
        chk("af_clear", cmd_almost_full, 0);
        chk("ovf_sticky", err_overflow, 1);

        // Orphan readdatavalid
        chk("orphan_before", err_orphan_rsp, 0);
        rdv_pulse(64'h5555_5555_5555_5555);
        chk("orphan_set", err_orphan_rsp, 1);
        chk("orphan_no_rsp", rsp_valid, 0);

        // Reset mid-burst: one read outstanding, two writes buffered
        push(1'b1, 1'b0, 18'h00500, 64'h0, 9'h7);
        step();
        avm_waitrequest = 1'b1;
        push(1'b0, 1'b0, 18'h00600, 64'h1, 9'h0);
        push(1'b0, 1'b0, 18'h00608, 64'h2, 9'h0);
        chk("mid_write_pending", avm_write, 1);
        reset = 1'b1;
        step();
        chk("mid_rst_write", avm_write, 0);
        chk("mid_rst_read", avm_read, 0);
        chk("mid_rst_addr", avm_address, 0);
        chk("mid_rst_be", avm_byteenable, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        chk("mid_rst_err", {err_overflow, err_orphan_rsp}, 0);
        chk("mid_rst_af", cmd_almost_full, 0);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        step();
        chk("post_rst_empty", {avm_read, avm_write}, 0);
        // Tag FIFO must be empty: returning data now is an orphan.
        rdv_pulse(64'h7777_7777_7777_7777);
        chk("post_rst_orphan", err_orphan_rsp, 1);
        chk("post_rst_no_rsp", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
